cdb_arbiter: RTL
================

// Module: cdb_arbiter
// PURPOSE
//  Writeback side of the execute/writeback handshake. Each execution unit (ALU, MULT, load buffer, ACU)
//  holds one result in a writeback register and raises <unit>_wr_valid. This block picks one result per
//  cycle, acks it with <unit>_wr_written and broadcasts it on the registered CDB to ROB and RSs.
//  Hazard logic reads the acks to compute <unit>_wr_enable = ~wr_valid | wr_written.
// PARAMETERS
//  NUM_SRC   4   number of writeback sources; index 0=ALU, 1=MULT, 2=LB, 3=ACU
//  TAG_W     5   ROB tag width
//  DATA_W    32  result value width
// PORTS
//  clock        in   1               sole clock, rising edge
//  reset        in   1               synchronous, active-low (0 = reset)
//  flush        in   1               branch misprediction squash
//  cdb_hold     in   1               consumer cannot accept a broadcast this cycle
//  src_valid    in   NUM_SRC         per-source wr_valid
//  src_tag      in   NUM_SRC*TAG_W   per-source ROB tag, source i at [i*TAG_W +: TAG_W]
//  src_value    in   NUM_SRC*DATA_W  per-source result, source i at [i*DATA_W +: DATA_W]
//  src_written  out  NUM_SRC         one-hot (or zero) grant/ack, combinational
//  cdb_valid    out  1               registered broadcast valid
//  cdb_tag      out  TAG_W           registered broadcast tag
//  cdb_value    out  DATA_W          registered broadcast value
//  cdb_src      out  log2(NUM_SRC)   index of the broadcasting source
// BEHAVIOUR
//  - Reset (reset==0 at a clock edge): cdb_valid=0, cdb_tag=0, cdb_value=0, cdb_src=0, rr_ptr=0.
//    src_written is forced 0 while reset==0.
//  - Grant condition: grant_en = reset & ~flush & ~cdb_hold & |src_valid.
//  - Round-robin: the winner is the first valid index at or after rr_ptr, searching upward mod NUM_SRC.
//    At most one src_written bit is set; it is set only when grant_en is 1.
//  - Ack latency 0: src_written[i] is asserted in the same cycle as the grant, so the source can reload
//    its writeback register at the same edge.
//  - Broadcast latency 1: at the edge after a grant, cdb_valid=1 and cdb_tag, cdb_value, cdb_src take
//    the winner's tag, value and index. cdb_valid is high for exactly one cycle per grant.
//  - Cycle with no grant: cdb_valid<=0 next cycle; cdb_tag, cdb_value and cdb_src hold their values.
//  - Pointer: on a grant, rr_ptr<=winner+1, wrapping from NUM_SRC-1 to 0. Without a grant, rr_ptr holds.
//  - flush: no grant that cycle, and cdb_valid<=0 at the next edge. A result already registered in the
//    cycle flush rises is still broadcast; ROB tag checks discard it. rr_ptr holds.
//  - cdb_hold: no grant; sources keep valid; rr_ptr holds; cdb_valid<=0 next cycle.
//    flush takes precedence over cdb_hold; the outcome is identical.
//  - Fairness: any source with valid held high is granted within NUM_SRC grant-enabled cycles.
//  - Values are passed through unmodified; no arithmetic on data. Tags are not checked.
//  - Reset mid-operation: a pending broadcast is dropped and the pointer returns to 0.
// TESTING
//  1. Reset: hold reset=0 two cycles with src_valid=4'b1111
//     -> src_written=0, cdb_valid=0; first cycle after release grants src 0.
//  2. Single source: src_valid=4'b0100, tag 5'd9, value 32'hDEAD_BEEF
//     -> src_written=4'b0100 same cycle; next cycle cdb_valid=1, tag=9, value=DEADBEEF, cdb_src=2.
//  3. Rotation: src_valid=4'b1111 held six cycles from rr_ptr=0
//     -> grants 0,1,2,3,0,1; cdb_valid stays high each following cycle.
//  4. Wrap: rr_ptr=3, src_valid=4'b0011 -> grant 0, then grant 1.
//  5. flush with src_valid=4'b0010 -> src_written=0; next cycle cdb_valid=0; rr_ptr unchanged.
//  6. cdb_hold=1 for 3 cycles with src_valid=4'b1000 -> no ack and no broadcast;
//     on release, ack src 3 and broadcast the next cycle.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin pick of one writeback result
// per cycle, zero-latency ack, registered one-cycle broadcast.
module cdb_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int TAG_W   = 5,
    parameter int DATA_W  = 32,
    localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      cdb_hold,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
    input  logic [NUM_SRC*DATA_W-1:0] src_value,
    output logic [NUM_SRC-1:0]        src_written,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_value,
    output logic [SRC_W-1:0]          cdb_src
);

    logic [SRC_W-1:0]  rr_ptr;
    logic [SRC_W-1:0]  rr_next;
    logic [SRC_W-1:0]  winner;
    logic [SRC_W-1:0]  idx;
    logic              found;
    logic              grant_en;
    logic [TAG_W-1:0]  win_tag;
    logic [DATA_W-1:0] win_value;

    // Reset, squash and back-pressure all block the grant.
    assign grant_en = reset & ~flush & ~cdb_hold & (|src_valid);

    // First valid source at or after rr_ptr, searching upward with wrap.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = SRC_W'((int'(rr_ptr) + k) % NUM_SRC);
            if (!found && src_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Select the winner's tag and value for the broadcast register.
    always_comb begin
        win_tag   = '0;
        win_value = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (SRC_W'(i) == winner) begin
                win_tag   = src_tag[i*TAG_W +: TAG_W];
                win_value = src_value[i*DATA_W +: DATA_W];
            end
        end
    end

    // One-hot ack in the grant cycle; pointer moves past the winner.
    always_comb begin
        src_written = '0;
        rr_next     = rr_ptr;
        if (grant_en) begin
            src_written = NUM_SRC'(1) << winner;
            if (winner == SRC_W'(NUM_SRC - 1))
                rr_next = '0;
            else
                rr_next = winner + 1'b1;
        end
    end

    // Broadcast register and round-robin pointer.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_value <= '0;
            cdb_src   <= '0;
            rr_ptr    <= '0;
        end else begin
            cdb_valid <= grant_en;
            rr_ptr    <= rr_next;
            if (grant_en) begin
                cdb_tag   <= win_tag;
                cdb_value <= win_value;
                cdb_src   <= winner;
            end
        end
    end

endmodule
